regfile_mp_scb: RTL and testbench
=================================

// Module: regfile_mp_scb
// PURPOSE
//  Multi-port register file with integrated busy scoreboard for the pipelined MIPS core.
//  Generalises the single-write, 2-read file: parametrised width, depth, read ports and write ports.
//  Adds async reset, optional same-cycle write->read bypass and per-register busy tracking for hazard detection.
//  Sits between the decode stage (reads, issue marking) and the writeback stage (writes, busy clear).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; depth = 2**ADDR_W
//  NUM_RD    2   number of read ports (>=1)
//  NUM_WR    2   number of write ports (>=1); higher index = higher priority
//  ZERO_REG  1   1: register 0 reads 0, writes to it are dropped, never busy
//  BYPASS    1   1: same-cycle write data forwarded to matching read ports
// PORTS
//  clk       in   1               clock, all state updates on rising edge
//  rst_n     in   1               reset, asynchronous, active-low
//  rd_addr   in   NUM_RD*ADDR_W   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//  rd_data   out  NUM_RD*DATA_W   packed read data, combinational
//  rd_busy   out  NUM_RD          busy flag of addressed register, combinational
//  wr_en     in   NUM_WR          write enable per write port
//  wr_addr   in   NUM_WR*ADDR_W   packed write addresses
//  wr_data   in   NUM_WR*DATA_W   packed write data
//  iss_en    in   1               mark iss_addr busy (instruction issued with this destination)
//  iss_addr  in   ADDR_W          destination register being issued
//  flush     in   1               clear all busy bits (pipeline flush)
//  busy_vec  out  2**ADDR_W       registered busy bit per register
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers 0, all busy bits 0; rd_data/rd_busy then reflect zeros.
//  Write: on posedge, for each wr_en[j]: rf[wr_addr[j]] <= wr_data[j].
//   - Multiple ports same address same cycle: highest-index enabled port wins.
//   - ZERO_REG=1: writes to address 0 dropped.
//  Read: combinational, rd_data[i] = rf[rd_addr[i]].
//   - ZERO_REG=1 and rd_addr[i]==0: rd_data[i]=0, rd_busy[i]=0, no bypass.
//   - BYPASS=1: if any wr_en[j] with wr_addr[j]==rd_addr[i] this cycle, rd_data[i] = wr_data of highest such j.
//   - BYPASS=0: write visible on read port the cycle after the edge (latency 1).
//  Scoreboard (per register busy bit, next-state priority high->low):
//   1. flush=1: all busy <= 0; iss_en in same cycle ignored.
//   2. iss_en=1: busy[iss_addr] <= 1, even if written same cycle (newer producer wins).
//   3. any wr_en[j] to addr a: busy[a] <= 0.
//   - ZERO_REG=1: busy[0] held 0; iss_addr==0 ignored.
//   - Writes still update rf during flush.
//  rd_busy[i] = busy[rd_addr[i]]; with BYPASS=1 forced 0 when a matching write occurs this cycle
//   (unless that write is overridden as busy by iss_en to same addr -- data still bypassed, busy stays 1).
//  busy_vec = registered busy bits, no bypass.
//  Reset mid-operation: state cleared immediately, in-flight writes that edge lost.
// STRUCTURE
//  Package regfile_pkg: default DATA_W/ADDR_W, reg-index constant ZERO_IDX, helper
//   function for priority-select of write port by address.
//  Sub-module regfile_scoreboard: busy-bit array, flush/issue/clear priority, busy_vec out.
//  Top: storage array, write-port priority, read muxes with bypass.
// TESTING
//  1. Reset: load rf[5]=0xDEADBEEF, assert rst_n=0 mid-cycle -> rd_data for addr5 = 0 immediately, busy_vec=0.
//  2. Dual write conflict: wr0 (addr3,0x11), wr1 (addr3,0x22) same edge -> rf[3]=0x22; BYPASS read same cycle = 0x22.
//  3. Zero register: write addr0=0xFFFFFFFF, iss_en addr0 -> rd_data=0, rd_busy=0, busy_vec[0]=0.
//  4. Scoreboard: iss_en addr7 -> next cycle busy_vec[7]=1; wr addr7=0x55 -> rd_busy=0 that cycle (BYPASS=1), busy_vec[7]=0 next.
//  5. Issue vs write same addr9 same cycle -> busy_vec[9]=1 next cycle, rf[9] updated.
//  6. flush with iss_en addr4 while busy {2,4,6} set -> busy_vec all 0 next cycle; concurrent write to reg2 lands.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file with busy scoreboard.
// Contents:
//   DEFAULT_DATA_W / DEFAULT_ADDR_W  default register width and address width
//   ZERO_IDX                         index of the hard-wired zero register
//   MAX_WR / WR_IDX_W                upper bound on write ports and width of a port index
//   wr_sel_t                         result of a write-port priority select (hit + port index)
//   wr_port_sel()                    picks the highest-index write port whose match bit is set
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_IDX       = 0;
    localparam int MAX_WR         = 16;
    localparam int WR_IDX_W       = 4;

    typedef struct packed {
        logic                hit;
        logic [WR_IDX_W-1:0] idx;
    } wr_sel_t;

    // Ascending scan so the last (highest-index) matching port is the one reported.
    function automatic wr_sel_t wr_port_sel(input logic [MAX_WR-1:0] match);
        wr_sel_t sel;
        sel.hit = 1'b0;
        sel.idx = '0;
        for (int j = 0; j < MAX_WR; j++) begin
            if (match[j]) begin
                sel.hit = 1'b1;
                sel.idx = WR_IDX_W'(j);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for hazard detection.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_addr         writeback ports; a write clears the busy bit of its destination
//   iss_en/iss_addr       issue of an instruction; marks its destination busy
//   flush                 clears every busy bit, and suppresses a same-cycle issue
//   busy_vec              registered busy bit per register
// Next-state priority per bit: flush > issue > write-clear > hold.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [2**ADDR_W-1:0]     busy_vec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;
    logic [DEPTH-1:0] clr_s;

    // Collect which registers are being written back this cycle.
    always_comb begin
        clr_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                clr_s[k] = clr_s[k] | (wr_en[j] & (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(k)));
            end
        end
    end

    // Resolve flush/issue/clear priority per register; the zero register never goes busy.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush) begin
                busy_nxt_s[k] = 1'b0;
            end else if (iss_en && (iss_addr == ADDR_W'(k))) begin
                busy_nxt_s[k] = 1'b1;
            end else if (clr_s[k]) begin
                busy_nxt_s[k] = 1'b0;
            end else begin
                busy_nxt_s[k] = busy_r[k];
            end
        end
        busy_nxt_s[ZERO_IDX] = (ZERO_REG != 0) ? 1'b0 : busy_nxt_s[ZERO_IDX];
    end

    // Busy bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy_vec = busy_r;

endmodule

// File: rtl/regfile_mp_scb.sv
// Multi-port register file with integrated busy scoreboard for the pipelined MIPS core.
// Decode reads operands and marks issued destinations busy; writeback writes results
// and clears busy.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears data and busy)
//   rd_addr/rd_data     NUM_RD packed read ports, combinational data
//   rd_busy             busy flag of each addressed register, combinational
//   wr_en/wr_addr/wr_data  NUM_WR packed write ports, higher index wins on conflict
//   iss_en/iss_addr     mark a destination busy
//   flush               clear all busy bits
//   busy_vec            registered busy bits
module regfile_mp_scb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [2**ADDR_W-1:0]     busy_vec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] rf_r [DEPTH];
    logic [DEPTH-1:0]  busy_s;

    // Storage: ports applied in ascending order so the highest enabled port's value lands last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                rf_r[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && !((ZERO_REG != 0) &&
                                  (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(ZERO_IDX)))) begin
                    rf_r[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_vec (busy_s)
    );

    assign busy_vec = busy_s;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] raddr_s;
        logic [NUM_WR-1:0] match_s;
        wr_sel_t           sel_s;
        logic              is_zero_s;
        logic              iss_hit_s;
        logic [DATA_W-1:0] rdat_s;
        logic              rbusy_s;

        assign raddr_s = rd_addr[gi*ADDR_W +: ADDR_W];

        // Which write ports target this read address in the current cycle.
        always_comb begin
            match_s = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                match_s[j] = wr_en[j] & (wr_addr[j*ADDR_W +: ADDR_W] == raddr_s);
            end
        end

        assign sel_s     = wr_port_sel(MAX_WR'(match_s));
        assign is_zero_s = (ZERO_REG != 0) && (raddr_s == ADDR_W'(ZERO_IDX));
        // An effective same-cycle issue keeps the register busy even though its write is bypassed.
        assign iss_hit_s = iss_en && !flush && (iss_addr == raddr_s);

        // Read mux: zero register, then forwarded write data, then stored value.
        always_comb begin
            if (is_zero_s) begin
                rdat_s  = '0;
                rbusy_s = 1'b0;
            end else if ((BYPASS != 0) && sel_s.hit) begin
                rdat_s  = wr_data[int'(sel_s.idx)*DATA_W +: DATA_W];
                rbusy_s = busy_s[raddr_s] & iss_hit_s;
            end else begin
                rdat_s  = rf_r[raddr_s];
                rbusy_s = busy_s[raddr_s];
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = rdat_s;
        assign rd_busy[gi]                  = rbusy_s;
    end

endmodule

// File: tb/tb_regfile_mp_scb.sv
// Self-checking bench for regfile_mp_scb (default parameters): directed scenarios with
// literal expectations plus randomized traffic compared every cycle against an array model.
module tb_regfile_mp_scb;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [31:0] busy_vec;

    logic [4:0]  ra [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];

    logic [31:0] m_rf [32];
    logic [31:0] m_busy;

    int checks = 0;
    int errors = 0;

    assign rd_addr = {ra[1], ra[0]};
    assign wr_addr = {wa[1], wa[0]};
    assign wr_data = {wd[1], wd[0]};

    regfile_mp_scb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        wr_en = 2'b00; iss_en = 1'b0; flush = 1'b0; iss_addr = 5'd0;
        wa[0] = 5'd0; wa[1] = 5'd0; wd[0] = 32'd0; wd[1] = 32'd0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_rf[k] = 32'd0;
        m_busy = 32'd0;
    endtask

    // Expected read outputs from the current model state and the inputs in flight.
    task automatic compare_all();
        logic [31:0] ed;
        logic        eb;
        int          hit;
        for (int i = 0; i < 2; i++) begin
            hit = -1;
            for (int j = 1; j >= 0; j--) begin
                if (hit < 0 && wr_en[j] && wa[j] == ra[i]) hit = j;
            end
            if (ra[i] == 5'd0) begin
                ed = 32'd0; eb = 1'b0;
            end else if (hit >= 0) begin
                ed = wd[hit];
                eb = m_busy[ra[i]] && iss_en && !flush && (iss_addr == ra[i]);
            end else begin
                ed = m_rf[ra[i]];
                eb = m_busy[ra[i]];
            end
            chk($sformatf("rd_data%0d", i), 64'(rd_data[i*32 +: 32]), 64'(ed));
            chk($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(eb));
        end
        chk("busy_vec", 64'(busy_vec), 64'(m_busy));
    endtask

    // Apply one clock edge worth of architectural effects to the model.
    task automatic model_update();
        for (int j = 0; j < 2; j++) begin
            if (wr_en[j] && wa[j] != 5'd0) m_rf[wa[j]] = wd[j];
        end
        for (int j = 0; j < 2; j++) begin
            if (wr_en[j]) m_busy[wa[j]] = 1'b0;
        end
        if (flush) m_busy = 32'd0;
        else if (iss_en && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        ra[0] = 5'd0; ra[1] = 5'd0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        ra[0] = 5'd5; ra[1] = 5'd31;
        #1;
        chk("reset_busy_vec", 64'(busy_vec), 64'h0);
        chk("reset_rd_data", rd_data, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Dual write conflict on reg3: port 1 wins, and is forwarded the same cycle.
        wr_en = 2'b11; wa[0] = 5'd3; wd[0] = 32'h11; wa[1] = 5'd3; wd[1] = 32'h22;
        ra[0] = 5'd3;
        #1 chk("dual_bypass", 64'(rd_data[31:0]), 64'h22);
        tick();
        idle();
        #1 chk("dual_stored", 64'(rd_data[31:0]), 64'h22);
        tick();

        // Zero register: write and issue both ignored.
        wr_en = 2'b01; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF; iss_en = 1'b1; iss_addr = 5'd0;
        ra[0] = 5'd0;
        #1 chk("zero_rd_data", 64'(rd_data[31:0]), 64'h0);
        chk("zero_rd_busy", 64'(rd_busy[0]), 64'h0);
        tick();
        idle();
        #1 chk("zero_busy_vec", 64'(busy_vec[0]), 64'h0);
        chk("zero_rd_data_after", 64'(rd_data[31:0]), 64'h0);
        tick();

        // Issue reg7, then write it back with a same-cycle read.
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        idle(); ra[0] = 5'd7;
        #1 chk("iss7_busy_vec", 64'(busy_vec[7]), 64'h1);
        chk("iss7_rd_busy", 64'(rd_busy[0]), 64'h1);
        wr_en = 2'b01; wa[0] = 5'd7; wd[0] = 32'h55;
        #1 chk("wb7_rd_busy", 64'(rd_busy[0]), 64'h0);
        chk("wb7_rd_data", 64'(rd_data[31:0]), 64'h55);
        tick();
        idle();
        #1 chk("wb7_busy_vec", 64'(busy_vec[7]), 64'h0);
        tick();

        // Issue and write reg9 in the same cycle: newer producer keeps it busy.
        iss_en = 1'b1; iss_addr = 5'd9; wr_en = 2'b10; wa[1] = 5'd9; wd[1] = 32'h99;
        ra[1] = 5'd9;
        #1 chk("iw9_bypass", 64'(rd_data[63:32]), 64'h99);
        tick();
        idle();
        #1 chk("iw9_busy_vec", 64'(busy_vec[9]), 64'h1);
        chk("iw9_rd_busy", 64'(rd_busy[1]), 64'h1);
        chk("iw9_rd_data", 64'(rd_data[63:32]), 64'h99);
        tick();

        // Busy on {2,4,6}, then flush with a concurrent issue of 4 and a write to 2.
        for (int r = 2; r <= 6; r += 2) begin
            idle(); iss_en = 1'b1; iss_addr = 5'(r);
            tick();
        end
        idle();
        #1 chk("pre_flush_busy", 64'(busy_vec & 32'h0000_0054), 64'h54);
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
        wr_en = 2'b01; wa[0] = 5'd2; wd[0] = 32'h2222;
        tick();
        idle(); ra[0] = 5'd2;
        #1 chk("flush_busy_vec", 64'(busy_vec), 64'h0);
        chk("flush_write_lands", 64'(rd_data[31:0]), 64'h2222);
        tick();

        // Randomized traffic with dense address reuse.
        for (int n = 0; n < 3000; n++) begin
            for (int j = 0; j < 2; j++) begin
                wa[j] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 7));
                wd[j] = $urandom;
            end
            wr_en    = 2'($urandom_range(0, 3));
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = ($urandom_range(0, 1) == 0) ? wa[$urandom_range(0, 1)]
                                                   : 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < 2; i++) begin
                ra[i] = ($urandom_range(0, 1) == 0) ? wa[$urandom_range(0, 1)]
                                                    : 5'($urandom_range(0, 7));
            end
            tick();
        end

        // Asynchronous reset mid-cycle after loading reg5 and making it busy.
        idle();
        wr_en = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF; iss_en = 1'b1; iss_addr = 5'd5;
        tick();
        idle(); ra[0] = 5'd5;
        #1 chk("pre_reset_rf5", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        chk("pre_reset_busy5", 64'(busy_vec[5]), 64'h1);
        #1 rst_n = 1'b0;
        model_reset();
        #1 chk("async_reset_rd5", 64'(rd_data[31:0]), 64'h0);
        chk("async_reset_busy_vec", 64'(busy_vec), 64'h0);
        // A write presented while reset is held must be lost.
        wr_en = 2'b01; wa[0] = 5'd5; wd[0] = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1 chk("reset_lost_write", 64'(rd_data[31:0]), 64'h0);
        tick();
        for (int n = 0; n < 20; n++) begin
            wr_en = 2'($urandom_range(0, 3));
            wa[0] = 5'($urandom_range(0, 7)); wa[1] = 5'($urandom_range(0, 7));
            wd[0] = $urandom; wd[1] = $urandom;
            iss_en = ($urandom_range(0, 1) == 0); iss_addr = 5'($urandom_range(0, 7));
            ra[0] = wa[0]; ra[1] = 5'($urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
